// File: rtl/sw_entry.sv
// ---------------------------------------------------------------------------
// sw_entry : operator-input front end for the CPU IN port.
//
// This block debounces three push-buttons. It builds a multi-nibble word from
// sw_nib, taking one nibble on each "enter" press. A "commit" press hands the
// finished word to the CPU through a valid/rd handshake.
//
// The word being entered is also brought out on entry/digits, so top-level
// logic can show it on the seven-segment digits.
//
// Ports
//   clk      in   1           system clock
//   rst      in   1           synchronous reset, active-high
//   btn_raw  in   3           raw buttons, asynchronous to clk:
//                             [0]=enter, [1]=commit, [2]=clear
//   sw_nib   in   4           nibble source, sampled on the enter event cycle
//   rd       in   1           CPU read strobe, only acted on while valid=1
//   data     out  DATA_WIDTH  committed word, held while valid=1
//   valid    out  1           committed word available
//   entry    out  DATA_WIDTH  word currently being entered
//   digits   out  3           number of nibbles entered so far, 0..NIBBLES
//
// Every output comes straight from a flop. No input has a combinational path
// to any output.
// ---------------------------------------------------------------------------
module sw_entry #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int DATA_WIDTH      = 16,
  parameter int NIBBLES         = DATA_WIDTH / 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            btn_raw,
  input  logic [3:0]            sw_nib,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] entry,
  output logic [2:0]            digits
);

  // Width of the debounce counter. It only has to reach DEBOUNCE_CYCLES-1.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]       DIG_MAX = 3'(NIBBLES);

  localparam int BTN_ENTER  = 0;
  localparam int BTN_COMMIT = 1;
  localparam int BTN_CLEAR  = 2;

  // One-cycle press events, one bit per button.
  logic [2:0] press;

  // -------------------------------------------------------------------------
  // Per-button conditioning chain:
  //   2-flop synchronizer -> debouncer -> rising-edge event register.
  // A press event is registered one cycle after the stable level rises.
  // Releases produce no event.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic             sync1_q;
      logic             sync2_q;
      logic             stable_q;
      logic             stable_dly_q;
      logic             press_q;
      logic [CNT_W-1:0] cnt_q;
      logic             differ_d;

      assign differ_d = (sync2_q != stable_q);

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_q      <= 1'b0;
          sync2_q      <= 1'b0;
          stable_q     <= 1'b0;
          stable_dly_q <= 1'b0;
          press_q      <= 1'b0;
          cnt_q        <= '0;
        end else begin
          sync1_q <= btn_raw[gi];
          sync2_q <= sync1_q;

          // The counter runs only while the synchronized level disagrees with
          // the stable level. Any agreement restarts it, so a glitch shorter
          // than DEBOUNCE_CYCLES never reaches the flip point.
          if (differ_d) begin
            if (cnt_q == CNT_MAX) begin
              stable_q <= sync2_q;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_q <= '0;
          end

          stable_dly_q <= stable_q;
          press_q      <= stable_q & ~stable_dly_q;
        end
      end

      assign press[gi] = press_q;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Entry / handshake state machine.
  // -------------------------------------------------------------------------
  typedef enum logic {
    COLLECT = 1'b0,
    READY   = 1'b1
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] entry_q;
  logic [2:0]            digits_q;

  // Shift the new nibble in at the bottom. On overflow the oldest nibble
  // falls off the top, and the digit count saturates.
  logic [DATA_WIDTH-1:0] entry_shift_d;
  logic [2:0]            digits_inc_d;

  assign entry_shift_d = {entry_q[DATA_WIDTH-5:0], sw_nib};
  assign digits_inc_d  = (digits_q < DIG_MAX) ? digits_q + 3'd1 : DIG_MAX;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= COLLECT;
      data_q   <= '0;
      valid_q  <= 1'b0;
      entry_q  <= '0;
      digits_q <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          // Coinciding events resolve as clear > commit > enter.
          // A commit that finds no digits is dropped. It still outranks
          // enter in that cycle.
          if (press[BTN_CLEAR]) begin
            entry_q  <= '0;
            digits_q <= '0;
          end else if (press[BTN_COMMIT]) begin
            if (digits_q != 3'd0) begin
              data_q   <= entry_q;
              valid_q  <= 1'b1;
              entry_q  <= '0;
              digits_q <= '0;
              state_q  <= READY;
            end
          end else if (press[BTN_ENTER]) begin
            entry_q  <= entry_shift_d;
            digits_q <= digits_inc_d;
          end
        end

        READY: begin
          // Button events are dropped here, not queued. data keeps its value
          // after the read, so the CPU sees a steady word until the next
          // commit.
          if (rd) begin
            valid_q <= 1'b0;
            state_q <= COLLECT;
          end
        end

        default: begin
          state_q <= COLLECT;
        end
      endcase
    end
  end

  assign data   = data_q;
  assign valid  = valid_q;
  assign entry  = entry_q;
  assign digits = digits_q;

endmodule
